// File: rtl/cpu_write_buffer.sv
// cpu_write_buffer: posted store FIFO between writeback and a Wishbone classic data bus.
// Stores drain one per bus cycle; pending-store address hits are flagged for load hazards.
module cpu_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] sel_i,
    output logic                stall_o,
    input  logic [ADDR_W-1:0]   ld_address_i,
    output logic                ld_hit_o,
    output logic                empty_o,
    output logic                err_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DATA_W / 8;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, BUS} state_e;

    logic [ADDR_W-1:0] fa_q [DEPTH];
    logic [DATA_W-1:0] fd_q [DEPTH];
    logic [SW-1:0]     fs_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    state_e            state_q;
    logic              cyc_q, stb_q, we_q, err_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SW-1:0]     sel_q;
    logic              enq, deq;

    assign enq     = we_i && count_q != FULL;
    assign deq     = state_q == BUS && cyc_q && stb_q && (wb_ack_i || wb_err_i);
    assign count_d = count_q + CW'(enq) - CW'(deq);

    assign stall_o  = count_q == FULL;
    assign empty_o  = count_q == '0 && state_q == IDLE;
    assign err_o    = err_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;

    // An entry is valid when its distance from rd_ptr is below count; the bus entry stays valid until terminated.
    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(i) - rd_ptr_q} < count_q && fa_q[i][ADDR_W-1:2] == ld_address_i[ADDR_W-1:2])
                ld_hit_o = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
                fs_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (enq) begin
                fa_q[wr_ptr_q] <= address_i;
                fd_q[wr_ptr_q] <= data_i;
                fs_q[wr_ptr_q] <= sel_i;
                wr_ptr_q       <= wr_ptr_q + PW'(1);
            end
            if (deq)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            err_q   <= deq && wb_err_i;
            if (state_q == IDLE) begin
                if (count_q != '0) begin
                    adr_q   <= fa_q[rd_ptr_q];
                    dat_q   <= fd_q[rd_ptr_q];
                    sel_q   <= fs_q[rd_ptr_q];
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    state_q <= BUS;
                end
            end else if (deq) begin
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                we_q    <= 1'b0;
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cpu_write_buffer.sv
// tb_cpu_write_buffer: directed bench for the posted store buffer with a simple Wishbone slave.
module tb_cpu_write_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        we_i;
    logic [31:0] address_i, data_i, ld_address_i;
    logic [3:0]  sel_i;
    logic        stall_o, ld_hit_o, empty_o, err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    int n_checks = 0;
    int n_errs   = 0;
    int errs     = 0;
    bit slave_en, slave_rand, busy;
    int wcnt, nseen, err_idx;
    logic [67:0] cur;
    logic [67:0] seen [$];

    cpu_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .address_i(address_i), .data_i(data_i),
        .sel_i(sel_i), .stall_o(stall_o), .ld_address_i(ld_address_i), .ld_hit_o(ld_hit_o),
        .empty_o(empty_o), .err_o(err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        we_i = 1'b1; address_i = a; data_i = d; sel_i = s;
        while (stall_o && n < 100) begin
            tick;
            n++;
        end
        if (n == 100) check("put_timeout", stall_o, 0);
        tick;
        we_i = 1'b0;
    endtask

    task automatic wait_empty(input int lim);
        int n = 0;
        while (n < lim) begin
            if (err_o) errs++;
            if (empty_o) break;
            tick;
            n++;
        end
        check("drain", empty_o, 1);
    endtask

    // Slave: acks after 0 (or random 0-3) wait states, records each terminated store, checks bus stability.
    initial begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; busy = 1'b0; wcnt = 0;
        forever begin
            tick;
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
            if (slave_en && wb_cyc_o && wb_stb_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = slave_rand ? int'($urandom_range(0, 3)) : 0;
                    cur  = {wb_adr_o, wb_dat_o, wb_sel_o};
                end else
                    check("bus_stable", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o}, {cur, 1'b1});
                if (wcnt == 0) begin
                    seen.push_back(cur);
                    if (nseen == err_idx) wb_err_i = 1'b1;
                    else wb_ack_i = 1'b1;
                    nseen++;
                    busy = 1'b0;
                end else
                    wcnt--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; we_i = 1'b0; address_i = '0; data_i = '0; sel_i = '0; ld_address_i = '0;
        slave_en = 1'b0; slave_rand = 1'b0; err_idx = -1; nseen = 0;
        #3;
        check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, 0);
        check("rst_flags", {stall_o, empty_o, ld_hit_o, err_o}, 4'b0100);
        tick;
        rst_i = 1'b0;
        tick;
        check("rst_release_empty", empty_o, 1);

        // single store, zero wait states
        slave_en = 1'b1; seen.delete(); nseen = 0;
        we_i = 1'b1; address_i = 32'h1000; data_i = 32'hDEADBEEF; sel_i = 4'hF;
        tick;
        we_i = 1'b0;
        check("single_pending", {empty_o, wb_cyc_o}, 2'b00);
        tick;
        check("single_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o},
              {3'b111, 32'h1000, 32'hDEADBEEF, 4'hF});
        tick;
        check("single_done_cyc", wb_cyc_o, 0);
        tick;
        check("single_empty", empty_o, 1);
        check("single_seen", {seen.size(), seen[0]}, {32'd1, 32'h1000, 32'hDEADBEEF, 4'hF});

        // fill with ack withheld
        slave_en = 1'b0; seen.delete(); nseen = 0;
        for (int k = 1; k <= 4; k++) begin
            we_i = 1'b1; address_i = 32'h100 * k; data_i = 32'hA000_0000 + k; sel_i = 4'(k);
            tick;
        end
        check("fill_stall", stall_o, 1);
        address_i = 32'h500; data_i = 32'hA000_0005; sel_i = 4'd5;
        repeat (3) tick;
        check("fill_hold", {stall_o, wb_cyc_o, wb_adr_o}, {2'b11, 32'h100});
        slave_en = 1'b1;
        for (int n = 0; n < 50 && stall_o; n++) tick;
        check("fill_unstall", stall_o, 0);
        tick;
        we_i = 1'b0;
        wait_empty(200);
        check("fill_count", seen.size(), 5);
        for (int k = 1; k <= 5 && k <= seen.size(); k++)
            check("fill_order", seen[k-1], {32'h100 * k, 32'hA000_0000 + k, 4'(k)});

        // random wait states, pointer wrap
        slave_rand = 1'b1; seen.delete(); nseen = 0;
        for (int k = 0; k < 20; k++)
            put(32'h4000 + 4 * k, 32'h5A5A_0000 ^ (k * 32'h0101_0101), 4'(k + 1));
        wait_empty(400);
        check("wrap_count", seen.size(), 20);
        for (int k = 0; k < 20 && k < seen.size(); k++)
            check("wrap_order", seen[k], {32'h4000 + 4 * k, 32'h5A5A_0000 ^ (k * 32'h0101_0101), 4'(k + 1)});
        slave_rand = 1'b0;

        // load hazard
        slave_en = 1'b0; seen.delete(); nseen = 0;
        we_i = 1'b1; address_i = 32'h2004; data_i = 32'h11; sel_i = 4'h3; ld_address_i = 32'h2004;
        #1;
        check("hit_enqueue_cycle", ld_hit_o, 0);
        tick;
        we_i = 1'b0;
        check("hit_exact", ld_hit_o, 1);
        ld_address_i = 32'h2006;
        #1;
        check("hit_same_word", ld_hit_o, 1);
        ld_address_i = 32'h2008;
        #1;
        check("hit_next_word", ld_hit_o, 0);
        ld_address_i = 32'h2006;
        slave_en = 1'b1;
        wait_empty(50);
        check("hit_after_ack", ld_hit_o, 0);

        // error on second of three stores
        slave_en = 1'b0; seen.delete(); nseen = 0; err_idx = 1; errs = 0;
        put(32'h3000, 32'h1, 4'h1);
        put(32'h3004, 32'h2, 4'h2);
        put(32'h3008, 32'h3, 4'h4);
        slave_en = 1'b1;
        wait_empty(100);
        tick;
        if (err_o) errs++;
        check("err_pulses", errs, 1);
        check("err_count", seen.size(), 3);
        if (seen.size() == 3) check("err_third", seen[2], {32'h3008, 32'h3, 4'h4});
        check("err_empty", empty_o, 1);
        err_idx = -1;

        // asynchronous reset mid bus cycle
        slave_en = 1'b0;
        put(32'h7000, 32'h7, 4'hF);
        put(32'h7004, 32'h8, 4'hF);
        put(32'h7008, 32'h9, 4'hF);
        check("arst_busy", {wb_cyc_o, wb_stb_o}, 2'b11);
        ld_address_i = 32'h7000;
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_bus_drop", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check("arst_flags", {stall_o, empty_o, ld_hit_o}, 3'b010);
        tick;
        rst_i = 1'b0;
        tick;
        tick;
        check("arst_release", {empty_o, stall_o, wb_cyc_o}, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
